// File: rtl/qpsk_symbol_sequencer.sv
// Pairs a serial bit stream into QPSK (I,Q) symbols and sequences the I/Q carrier
// generators: enable while a symbol runs, one-cycle reset pulse whenever output stops.
module qpsk_symbol_sequencer #(
    parameter int SAMPLES_PER_CYCLE = 52,
    parameter int CYCLES_PER_SYMBOL = 1,
    parameter int CNT_W             = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             i_data,
    output logic             q_data,
    output logic             carrier_en,
    output logic             gen_reset,
    output logic             symbol_start,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             busy,
    output logic             underrun
);

    localparam int SYM_LEN = SAMPLES_PER_CYCLE * CYCLES_PER_SYMBOL;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SYM_LEN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic             i_stage, q_stage, half, pair_full;
    logic             i_stage_n, q_stage_n, half_n, pair_full_n;
    logic             i_data_n, q_data_n, carrier_en_n, gen_reset_n, symbol_start_n;
    logic             busy_n, underrun_n;
    logic [CNT_W-1:0] sample_cnt_n;
    logic             take, load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            i_stage      <= 1'b0;
            q_stage      <= 1'b0;
            half         <= 1'b0;
            pair_full    <= 1'b0;
            bit_ready    <= 1'b1;
            i_data       <= 1'b0;
            q_data       <= 1'b0;
            carrier_en   <= 1'b0;
            gen_reset    <= 1'b1;
            symbol_start <= 1'b0;
            sample_cnt   <= '0;
            busy         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_n;
            i_stage      <= i_stage_n;
            q_stage      <= q_stage_n;
            half         <= half_n;
            pair_full    <= pair_full_n;
            bit_ready    <= !pair_full_n;
            i_data       <= i_data_n;
            q_data       <= q_data_n;
            carrier_en   <= carrier_en_n;
            gen_reset    <= gen_reset_n;
            symbol_start <= symbol_start_n;
            sample_cnt   <= sample_cnt_n;
            busy         <= busy_n;
            underrun     <= underrun_n;
        end
    end

    always_comb begin
        state_n        = state;
        i_stage_n      = i_stage;
        q_stage_n      = q_stage;
        half_n         = half;
        pair_full_n    = pair_full;
        i_data_n       = i_data;
        q_data_n       = q_data;
        carrier_en_n   = carrier_en;
        gen_reset_n    = 1'b0;
        symbol_start_n = 1'b0;
        sample_cnt_n   = sample_cnt;
        busy_n         = busy;
        underrun_n     = underrun;
        load           = 1'b0;

        // take and load are mutually exclusive: one needs an empty stage, the other a full one
        take = bit_valid && !pair_full;
        if (take) begin
            if (!half) begin
                i_stage_n = bit_in;
                half_n    = 1'b1;
            end else begin
                q_stage_n   = bit_in;
                half_n      = 1'b0;
                pair_full_n = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                carrier_en_n = 1'b0;
                busy_n       = 1'b0;
                sample_cnt_n = '0;
                if (enable && pair_full) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                sample_cnt_n = sample_cnt + CNT_W'(1);
                if (sample_cnt == LAST_SAMPLE) begin
                    if (enable && pair_full) begin
                        load = 1'b1;
                    end else begin
                        // starved only counts when the stream was still wanted
                        if (enable) underrun_n = 1'b1;
                        gen_reset_n  = 1'b1;
                        carrier_en_n = 1'b0;
                        busy_n       = 1'b0;
                        sample_cnt_n = '0;
                        state_n      = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            i_data_n       = i_stage;
            q_data_n       = q_stage;
            pair_full_n    = 1'b0;
            sample_cnt_n   = '0;
            symbol_start_n = 1'b1;
            carrier_en_n   = 1'b1;
            busy_n         = 1'b1;
        end
    end

endmodule
